// File: rtl/parameterized_dual_port_ram.sv
// Simple dual-port RAM (one write port with byte enables, one read port) on a single clock,
// with a post-reset clear sequence, selectable read-during-write behaviour and optional output register.
module parameterized_dual_port_ram #(
    parameter int unsigned DEPTH          = 4096,
    parameter int unsigned ADDR_WIDTH     = 12,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BYTE_WIDTH     = 8,
    parameter int unsigned RDW_MODE       = 0,
    parameter int unsigned OUT_REG        = 1,
    parameter int unsigned CLEAR_ON_RESET = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    output logic                             ready,
    input  logic                             we,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] wbe,
    input  logic [ADDR_WIDTH-1:0]            waddr,
    input  logic [DATA_WIDTH-1:0]            din,
    input  logic                             re,
    input  logic [ADDR_WIDTH-1:0]            raddr,
    output logic [DATA_WIDTH-1:0]            dout,
    output logic                             dout_valid
);
    localparam int unsigned NUM_LANES = DATA_WIDTH / BYTE_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic                    ready_q;
    logic                    clr_we_c;
    logic                    wr_in_range_c, rd_in_range_c;
    logic                    wr_fire_c, rd_fire_c;
    logic [DATA_WIDTH-1:0]   rd_word_c;
    logic [DATA_WIDTH-1:0]   dout_q;
    logic                    dout_valid_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Control state: clear counter walks every address once, then the ports open
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= (state_d == ST_READY);
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we_c  = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_we_c  = 1'b1;
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                    if (clr_cnt_q == LAST_ADDR) begin
                        state_d = ST_READY;
                    end
                end else begin
                    state_d = ST_READY;
                end
            end
            default: state_d = state_q;
        endcase
    end

    assign wr_in_range_c = ({1'b0, waddr} < DEPTH_EXT);
    assign rd_in_range_c = ({1'b0, raddr} < DEPTH_EXT);
    assign wr_fire_c     = ready_q & we & wr_in_range_c;
    assign rd_fire_c     = ready_q & re;

    // Storage has no reset; the clear sequence owns initialisation
    always_ff @(posedge clk) begin
        if (clr_we_c) begin
            mem_q[clr_cnt_q] <= CLEAR_VALUE;
        end else if (wr_fire_c) begin
            for (int i = 0; i < int'(NUM_LANES); i++) begin
                if (wbe[i]) begin
                    mem_q[waddr][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[i*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    // Read word: out-of-range reads return zero; mode 1 forwards enabled lanes of a colliding write
    always_comb begin
        rd_word_c = '0;
        if (rd_in_range_c) begin
            rd_word_c = mem_q[raddr];
            if ((RDW_MODE != 0) && wr_fire_c && (waddr == raddr)) begin
                for (int i = 0; i < int'(NUM_LANES); i++) begin
                    if (wbe[i]) begin
                        rd_word_c[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
                    end
                end
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s1_data_q;
            logic                  s1_vld_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_data_q    <= '0;
                    s1_vld_q     <= 1'b0;
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    s1_vld_q     <= rd_fire_c;
                    dout_valid_q <= s1_vld_q;
                    if (rd_fire_c) begin
                        s1_data_q <= rd_word_c;
                    end
                    if (s1_vld_q) begin
                        dout_q <= s1_data_q;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q       <= '0;
                    dout_valid_q <= 1'b0;
                end else begin
                    dout_valid_q <= rd_fire_c;
                    if (rd_fire_c) begin
                        dout_q <= rd_word_c;
                    end
                end
            end
        end
    endgenerate

    assign ready      = ready_q;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;

endmodule
